// File: rtl/bf_io_pkg.sv
// Shared types and constants for the brainfuck core I/O port controller.
package bf_io_pkg;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    I_IDLE   = 2'd0,
    I_PULSE  = 2'd1,
    I_GAP    = 2'd2,
    I_SAMPLE = 2'd3
  } in_state_t;

  typedef enum logic [1:0] {
    O_IDLE  = 2'd0,
    O_SETUP = 2'd1,
    O_HIGH  = 2'd2,
    O_GAP   = 2'd3
  } out_state_t;
endpackage

// File: rtl/bf_io_port_if.sv
// CPU request/response and byte-device signals of the I/O port.
// master = CPU plus devices, slave = the port controller.
interface bf_io_port_if;
  import bf_io_pkg::*;

  logic              rd_req;
  logic              rd_ready;
  logic              rd_valid;
  logic [BYTE_W-1:0] rd_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [BYTE_W-1:0] wr_data;
  logic              out_empty;
  logic [BYTE_W-1:0] in;
  logic              setready;
  logic [BYTE_W-1:0] out;
  logic              ready;

  modport master (
    output rd_req, wr_valid, wr_data, in,
    input  rd_ready, rd_valid, rd_data, wr_ready, out_empty, setready, out, ready
  );

  modport slave (
    input  rd_req, wr_valid, wr_data, in,
    output rd_ready, rd_valid, rd_data, wr_ready, out_empty, setready, out, ready
  );
endinterface

// File: rtl/bf_io_fifo.sv
// Byte FIFO for the output path; pointers wrap modulo DEPTH and a separate
// count register tells full from empty.
module bf_io_fifo
  import bf_io_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [BYTE_W-1:0]      push_data,
  input  logic                   pop,
  output logic [BYTE_W-1:0]      head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       count_q;
  logic [AW:0]       count_d;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Storage is not reset; only the pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
endmodule

// File: rtl/bf_io_port.sv
// Converts single-cycle ',' / '.' requests into timed setready/ready strobes;
// output bytes are buffered so '.' bursts do not stall the core.
module bf_io_port
  import bf_io_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 1
) (
  input logic         clk,
  input logic         rst_n,
  bf_io_port_if.slave bus
);
  localparam int CNT_MAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] P_LAST = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] G_LAST = CW'(GAP_W - 1);

  in_state_t         i_state_q;
  logic [CW-1:0]     i_cnt_q;
  logic              setready_q;
  logic              rd_valid_q;
  logic [BYTE_W-1:0] rd_data_q;

  // Advance first, then sample: the device head is undefined before an advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_state_q  <= I_IDLE;
      i_cnt_q    <= '0;
      setready_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= 1'b0;
      case (i_state_q)
        I_IDLE: begin
          if (bus.rd_req) begin
            i_state_q  <= I_PULSE;
            setready_q <= 1'b1;
            i_cnt_q    <= '0;
          end
        end
        I_PULSE: begin
          if (i_cnt_q == P_LAST) begin
            i_state_q  <= I_GAP;
            setready_q <= 1'b0;
            i_cnt_q    <= '0;
          end else begin
            i_cnt_q <= i_cnt_q + 1'b1;
          end
        end
        I_GAP: begin
          if (i_cnt_q == G_LAST) begin
            i_state_q <= I_SAMPLE;
            i_cnt_q   <= '0;
          end else begin
            i_cnt_q <= i_cnt_q + 1'b1;
          end
        end
        I_SAMPLE: begin
          rd_data_q  <= bus.in;
          rd_valid_q <= 1'b1;
          i_state_q  <= I_IDLE;
        end
        default: i_state_q <= I_IDLE;
      endcase
    end
  end

  logic                   fifo_push;
  logic                   fifo_pop;
  logic [BYTE_W-1:0]      fifo_head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;

  out_state_t        o_state_q;
  logic [CW-1:0]     o_cnt_q;
  logic              ready_q;
  logic [BYTE_W-1:0] out_q;

  assign fifo_push = bus.wr_valid && !fifo_full;
  assign fifo_pop  = (o_state_q == O_HIGH) && (o_cnt_q == P_LAST);

  bf_io_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fifo_push),
    .push_data(bus.wr_data),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_state_q <= O_IDLE;
      o_cnt_q   <= '0;
      ready_q   <= 1'b0;
      out_q     <= '0;
    end else begin
      case (o_state_q)
        O_IDLE: begin
          if (!fifo_empty) begin
            out_q     <= fifo_head;
            o_state_q <= O_SETUP;
          end
        end
        O_SETUP: begin
          ready_q   <= 1'b1;
          o_cnt_q   <= '0;
          o_state_q <= O_HIGH;
        end
        O_HIGH: begin
          if (fifo_pop) begin
            ready_q   <= 1'b0;
            o_cnt_q   <= '0;
            o_state_q <= O_GAP;
          end else begin
            o_cnt_q <= o_cnt_q + 1'b1;
          end
        end
        O_GAP: begin
          if (o_cnt_q == G_LAST) begin
            // Chain straight into the next setup so bursts run at 1+PULSE_W+GAP_W.
            if (!fifo_empty) begin
              out_q     <= fifo_head;
              o_state_q <= O_SETUP;
            end else begin
              o_state_q <= O_IDLE;
            end
          end else begin
            o_cnt_q <= o_cnt_q + 1'b1;
          end
        end
        default: o_state_q <= O_IDLE;
      endcase
    end
  end

  assign bus.rd_ready  = (i_state_q == I_IDLE);
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.setready  = setready_q;
  assign bus.wr_ready  = !fifo_full;
  assign bus.out       = out_q;
  assign bus.ready     = ready_q;
  assign bus.out_empty = (fifo_count == '0) && (o_state_q == O_IDLE);
endmodule
